// File: rtl/stencil_window_feeder.sv
// Sliding ST-wide window builder over a serial FP32 stream, restarting at each row boundary.
// Emits window/weight operand pairs through a one-entry output register.
module stencil_window_feeder #(
    parameter int unsigned BW      = 32,
    parameter int unsigned ST      = 3,
    parameter int unsigned ROW_LEN = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [BW-1:0]      io_in_data,
    input  logic               io_wt_load,
    input  logic [BW*ST-1:0]   io_wt_data,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [BW*ST-1:0]   io_out_data,
    output logic [BW*ST-1:0]   io_out_weight,
    output logic               io_out_last
);

    localparam int unsigned CW = $clog2(ROW_LEN);
    localparam logic [CW-1:0] COL_LAST     = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] COL_FILL_END = CW'(ST - 2);

    typedef enum logic {FILL, STREAM} state_t;

    state_t                  state;
    logic [CW-1:0]           col;
    logic [BW*(ST-1)-1:0]    shift_reg;
    logic [BW*ST-1:0]        weight;
    logic [BW*ST-1:0]        window;
    logic                    accept;
    logic                    issue;

    always_comb begin
        io_in_ready = !reset && (!io_out_valid || io_out_ready);
        accept      = io_in_valid && io_in_ready;
        issue       = accept && (state == STREAM);
        window      = {shift_reg, io_in_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= FILL;
            col           <= '0;
            shift_reg     <= '0;
            weight        <= '0;
            io_out_valid  <= 1'b0;
            io_out_last   <= 1'b0;
            io_out_data   <= '0;
            io_out_weight <= '0;
        end else begin
            if (io_wt_load)
                weight <= io_wt_data;

            if (accept) begin
                case (state)
                    FILL: begin
                        shift_reg <= window[BW*(ST-1)-1:0];
                        col       <= col + 1'b1;
                        if (col == COL_FILL_END)
                            state <= STREAM;
                    end
                    STREAM: begin
                        // Row end clears history so no window straddles two rows
                        if (col == COL_LAST) begin
                            shift_reg <= '0;
                            col       <= '0;
                            state     <= FILL;
                        end else begin
                            shift_reg <= window[BW*(ST-1)-1:0];
                            col       <= col + 1'b1;
                        end
                    end
                    default: state <= FILL;
                endcase
            end

            if (issue) begin
                io_out_valid  <= 1'b1;
                io_out_data   <= window;
                io_out_weight <= io_wt_load ? io_wt_data : weight;
                io_out_last   <= (col == COL_LAST);
            end else if (io_out_ready) begin
                io_out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stencil_window_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a row-queue reference model.
module tb_stencil_window_feeder;

    localparam int unsigned BW      = 32;
    localparam int unsigned ST      = 3;
    localparam int unsigned ROW_LEN = 16;
    localparam int unsigned W       = BW * ST;

    logic           clock = 1'b0;
    logic           reset;
    logic           io_in_valid;
    logic           io_in_ready;
    logic [BW-1:0]  io_in_data;
    logic           io_wt_load;
    logic [W-1:0]   io_wt_data;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_data;
    logic [W-1:0]   io_out_weight;
    logic           io_out_last;

    stencil_window_feeder #(.BW(BW), .ST(ST), .ROW_LEN(ROW_LEN)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_data    (io_in_data),
        .io_wt_load    (io_wt_load),
        .io_wt_data    (io_wt_data),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_data   (io_out_data),
        .io_out_weight (io_out_weight),
        .io_out_last   (io_out_last)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;
    int unsigned win_cnt  = 0;

    // Reference model: samples of the current row, weight register, output register
    logic [BW-1:0] row_q[$];
    logic [W-1:0]  m_wt;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [W-1:0]  m_weight;
    logic          m_last;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        row_q.delete();
        m_wt     = '0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_weight = '0;
        m_last   = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid",  W'(io_out_valid), W'(m_valid));
        check("out_last",   W'(io_out_last),  W'(m_last));
        check("out_data",   io_out_data,      m_data);
        check("out_weight", io_out_weight,    m_weight);
    endtask

    // One clock: drive at the falling edge, predict, check after the next falling edge
    task automatic step(input logic v, input logic [BW-1:0] d, input logic ld,
                        input logic [W-1:0] w, input logic ordy);
        logic          exp_rdy;
        logic [W-1:0]  win;
        int            n;
        io_in_valid  = v;
        io_in_data   = d;
        io_wt_load   = ld;
        io_wt_data   = w;
        io_out_ready = ordy;
        #1;
        exp_rdy = !m_valid || ordy;
        check("in_ready", W'(io_in_ready), W'(exp_rdy));
        if (v && exp_rdy) begin
            row_q.push_back(d);
            n = row_q.size();
            if (n >= int'(ST)) begin
                win = '0;
                for (int i = n - int'(ST); i < n; i++) win = (win << BW) | W'(row_q[i]);
                m_valid  = 1'b1;
                m_data   = win;
                m_weight = ld ? w : m_wt;
                m_last   = (n == int'(ROW_LEN));
                if (n == int'(ROW_LEN)) row_q.delete();
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (ld) m_wt = w;
        @(posedge clock);
        @(negedge clock);
        if (io_out_valid) win_cnt++;
        check_outputs();
    endtask

    task automatic mid_reset();
        io_in_valid = 1'b0;
        io_wt_load  = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("rst_in_ready", W'(io_in_ready), '0);
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [BW-1:0] rnd32();
        return BW'($urandom);
    endfunction

    initial begin
        logic [W-1:0] wt_a;
        logic [W-1:0] wt_b;
        reset = 1'b1;
        io_in_valid = 1'b0; io_in_data = '0; io_wt_load = 1'b0;
        io_wt_data = '0; io_out_ready = 1'b1;
        model_clear();
        #1;
        check("rst_in_ready", W'(io_in_ready), '0);
        check_outputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Unit weights, unit samples
        wt_a = {3{32'h3F800000}};
        step(0, '0, 1, wt_a, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h3F800000, 0, '0, 1);
        check("t1_data", io_out_data, 96'h3F8000003F8000003F800000);

        // Distinct samples and weights: element order
        wt_b = 96'h40000000_40800000_C0000000;
        step(0, '0, 1, wt_b, 1);
        step(1, 32'hC0A00000, 0, '0, 1);
        step(1, 32'hBF800000, 0, '0, 1);
        step(1, 32'h40400000, 0, '0, 1);
        check("t2_data",   io_out_data,   96'hC0A00000BF80000040400000);
        check("t2_weight", io_out_weight, wt_b);

        // Finish the row, then count windows over one full row
        for (int i = 0; i < 10; i++) step(1, rnd32(), 0, '0, 1);
        win_cnt = 0;
        for (int i = 0; i < int'(ROW_LEN); i++) step(1, rnd32(), 0, '0, 1);
        check("t3_win_count", W'(win_cnt), W'(ROW_LEN - ST + 1));

        // Back-pressure with a pending pair
        for (int i = 0; i < 4; i++) step(1, rnd32(), 0, '0, 1);
        for (int i = 0; i < 5; i++) step(1, rnd32(), 0, '0, 0);
        for (int i = 0; i < 4; i++) step(1, rnd32(), 0, '0, 1);

        // Weight load coincident with issue, then load after issue while stalled
        for (int i = 0; i < 4; i++) step(1, rnd32(), 0, '0, 1);
        step(1, rnd32(), 1, {3{rnd32()}}, 0);
        step(0, '0, 1, {3{rnd32()}}, 0);
        step(0, '0, 0, '0, 1);
        step(1, rnd32(), 0, '0, 1);

        // Reset mid-row
        mid_reset();
        for (int i = 0; i < 7; i++) step(1, rnd32(), 0, '0, 1);
        mid_reset();
        for (int i = 0; i < 4; i++) step(1, rnd32(), 0, '0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rnd32(),
                 ($urandom_range(0, 9) == 0), {rnd32(), rnd32(), rnd32()},
                 ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 999) == 0) mid_reset();
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
